// File: rtl/alarm_pio_in_s1.sv
// Avalon-MM input PIO: 2-flop synchronizer, optional per-bit debounce, sticky W1C edge capture, level irq.
// Build option: define ALARM_PIO_DEBOUNCE_EN to insert a debounce filter on every input line.

`ifdef ALARM_PIO_DEBOUNCE_EN
module alarm_pio_in_s1_deb #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic sync_i,
    output logic filt_o
);
    localparam logic [15:0] LAST = 16'(CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        filt_q, filt_d;

    // The count only runs while the synchronized input disagrees with the accepted value.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync_i != filt_q) begin
            if (cnt_q == LAST) filt_d = sync_i;
            else               cnt_d  = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt_o = filt_q;
endmodule
`endif

module alarm_pio_in_s1 #(
    parameter int WIDTH           = 7,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] sync1_q, sync2_q, filt, filt_prev_q, edge_det;
    logic [WIDTH-1:0] mask_q, mask_d, cap_q, cap_d, clr;
    logic [31:0]      rdata_q, rdata_d;
    logic             irq_q, irq_d;
    logic             wr_en;
    logic             unused_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end

`ifdef ALARM_PIO_DEBOUNCE_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        alarm_pio_in_s1_deb #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk    (clk),
            .reset  (reset),
            .sync_i (sync2_q[i]),
            .filt_o (filt[i])
        );
    end
`else
    logic unused_deb_cfg;
    assign filt           = sync2_q;
    assign unused_deb_cfg = (DEBOUNCE_CYCLES != 0);
`endif

    always_comb begin
        case (EDGE_TYPE)
            1:       edge_det = ~filt & filt_prev_q;
            2:       edge_det = filt ^ filt_prev_q;
            default: edge_det = filt & ~filt_prev_q;
        endcase
    end

    assign wr_en        = chipselect & ~write_n;
    assign clr          = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    assign unused_wdata = ^writedata;

    // OR-ing the edge in after the clear lets a same-cycle edge beat the W1C.
    always_comb begin
        cap_d  = (cap_q & ~clr) | edge_det;
        mask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
        irq_d  = |(cap_q & mask_q);
    end

    always_comb begin
        rdata_d = '0;
        case (address)
            2'd0:    rdata_d[WIDTH-1:0] = filt;
            2'd2:    rdata_d[WIDTH-1:0] = mask_q;
            2'd3:    rdata_d[WIDTH-1:0] = cap_q;
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_prev_q <= '0;
            mask_q      <= '0;
            cap_q       <= '0;
            rdata_q     <= '0;
            irq_q       <= 1'b0;
        end else begin
            filt_prev_q <= filt;
            mask_q      <= mask_d;
            cap_q       <= cap_d;
            rdata_q     <= rdata_d;
            irq_q       <= irq_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = irq_q;
endmodule

// File: tb/tb_alarm_pio_in_s1.sv
// Bench for alarm_pio_in_s1: register table, directed corner sequences, random traffic vs. a reference model.
// Two instances share the bus and inputs: rising-edge capture and any-edge capture.
module tb_alarm_pio_in_s1;
    localparam int W = 7;
    localparam int D = 16;
`ifdef ALARM_PIO_DEBOUNCE_EN
    localparam int FL = 2 + D;
`else
    localparam int FL = 2;
`endif
    localparam int ST = FL + 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [W-1:0]  in_port = '0;
    logic [31:0]   rd0, rd2;
    logic          irq0, irq2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alarm_pio_in_s1 #(.WIDTH(W), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq0)
    );

    alarm_pio_in_s1 #(.WIDTH(W), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(D)) dut2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd2), .irq(irq2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: inputs seen through a 2-sample delay line; with debounce a line
    // is accepted once it has read the same new value for D consecutive samples.
    logic [W-1:0] m_smp0, m_smp1, m_filt, m_filtd, m_mask, m_cap0, m_cap2;
    logic [W-1:0] mn_filt, mn_mask, mn_cap0, mn_cap2, mclr;
    logic [31:0]  m_rd0, m_rd2, mn_rd0, mn_rd2;
    logic         m_irq0, m_irq2;
    logic         mwr;
`ifdef ALARM_PIO_DEBOUNCE_EN
    int           m_run [W];
    int           mn_run [W];
    logic [W-1:0] m_lsync;
`endif

    always_comb begin
        mwr  = chipselect && !write_n;
        mclr = (mwr && address == 2'd3) ? writedata[W-1:0] : '0;
`ifdef ALARM_PIO_DEBOUNCE_EN
        mn_run  = m_run;
        mn_filt = m_filt;
        for (int i = 0; i < W; i++) begin
            if (m_smp1[i] == m_lsync[i]) mn_run[i] = (m_run[i] >= D) ? D : m_run[i] + 1;
            else                         mn_run[i] = 1;
            if (mn_run[i] >= D) mn_filt[i] = m_smp1[i];
        end
`else
        mn_filt = m_smp0;
`endif
        mn_cap0 = (m_cap0 & ~mclr) | (m_filt & ~m_filtd);
        mn_cap2 = (m_cap2 & ~mclr) | (m_filt ^ m_filtd);
        mn_mask = (mwr && address == 2'd2) ? writedata[W-1:0] : m_mask;
        mn_rd0  = '0;
        mn_rd2  = '0;
        case (address)
            2'd0: begin mn_rd0 = {25'd0, m_filt}; mn_rd2 = {25'd0, m_filt}; end
            2'd2: begin mn_rd0 = {25'd0, m_mask}; mn_rd2 = {25'd0, m_mask}; end
            2'd3: begin mn_rd0 = {25'd0, m_cap0}; mn_rd2 = {25'd0, m_cap2}; end
            default: ;
        endcase
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_smp0 <= '0; m_smp1 <= '0; m_filt <= '0; m_filtd <= '0;
            m_mask <= '0; m_cap0 <= '0; m_cap2 <= '0;
            m_rd0 <= '0; m_rd2 <= '0; m_irq0 <= 1'b0; m_irq2 <= 1'b0;
`ifdef ALARM_PIO_DEBOUNCE_EN
            m_lsync <= '0;
            for (int i = 0; i < W; i++) m_run[i] <= 0;
`endif
        end else begin
            m_smp0 <= in_port; m_smp1 <= m_smp0;
            m_filt <= mn_filt; m_filtd <= m_filt;
            m_mask <= mn_mask; m_cap0 <= mn_cap0; m_cap2 <= mn_cap2;
            m_rd0 <= mn_rd0; m_rd2 <= mn_rd2;
            m_irq0 <= |(m_cap0 & m_mask);
            m_irq2 <= |(m_cap2 & m_mask);
`ifdef ALARM_PIO_DEBOUNCE_EN
            m_lsync <= m_smp1;
            m_run   <= mn_run;
`endif
        end
    end

    always @(negedge clk) begin
        chk("mdl_rd0", rd0, m_rd0);
        chk("mdl_irq0", {31'd0, irq0}, {31'd0, m_irq0});
        chk("mdl_rd2", rd2, m_rd2);
        chk("mdl_irq2", {31'd0, irq2}, {31'd0, m_irq2});
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        step(1);
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic rd(input logic [1:0] a);
        address = a;
        step(1);
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vt [14];

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{2'd0, 1'b0, 1'b1, 32'h0,        32'h0,  1'b0};
        vt[1]  = '{2'd1, 1'b0, 1'b1, 32'h0,        32'h0,  1'b0};
        vt[2]  = '{2'd2, 1'b0, 1'b1, 32'h0,        32'h0,  1'b0};
        vt[3]  = '{2'd3, 1'b0, 1'b1, 32'h0,        32'h0,  1'b0};
        vt[4]  = '{2'd2, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0,  1'b0};
        vt[5]  = '{2'd2, 1'b0, 1'b1, 32'h0,        32'h7F, 1'b0};
        vt[6]  = '{2'd1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0,  1'b0};
        vt[7]  = '{2'd1, 1'b0, 1'b1, 32'h0,        32'h0,  1'b0};
        vt[8]  = '{2'd0, 1'b1, 1'b0, 32'h7F,       32'h0,  1'b0};
        vt[9]  = '{2'd0, 1'b0, 1'b1, 32'h0,        32'h0,  1'b0};
        vt[10] = '{2'd2, 1'b1, 1'b0, 32'h3C,       32'h7F, 1'b0};
        vt[11] = '{2'd2, 1'b0, 1'b0, 32'h0,        32'h3C, 1'b0};
        vt[12] = '{2'd2, 1'b1, 1'b1, 32'h0,        32'h3C, 1'b0};
        vt[13] = '{2'd2, 1'b1, 1'b0, 32'h7F,       32'h3C, 1'b0};

        #1 reset = 1'b1;
        step(3);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            address = vt[i].addr; chipselect = vt[i].cs; write_n = vt[i].wn; writedata = vt[i].wd;
            step(1);
            chk($sformatf("vec%0d_rd", i), rd0, vt[i].exp_rd);
            chk($sformatf("vec%0d_irq", i), {31'd0, irq0}, {31'd0, vt[i].exp_irq});
        end
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;

        // Rising capture and end-to-end irq latency
        address = 2'd3; in_port = 7'h05;
        step(FL + 1);
        chk("rise_irq_early", {31'd0, irq0}, 32'd0);
        step(1);
        chk("rise_irq", {31'd0, irq0}, 32'd1);
        chk("rise_cap", rd0, 32'h05);
        rd(2'd0);
        chk("rise_data", rd0, 32'h05);

        // W1C, then clear-to-irq-low
        wr(2'd3, 32'h01);
        rd(2'd3);
        chk("w1c_bit0", rd0, 32'h04);
        chk("w1c_irq", {31'd0, irq0}, 32'd1);
        in_port = 7'h01;
        step(ST);
        wr(2'd3, 32'h04);
        rd(2'd3);
        chk("w1c_bit2", rd0, 32'h0);
        chk("w1c_irq_low", {31'd0, irq0}, 32'd0);

        // Clear and new edge on the same clock: edge wins
        in_port = 7'h05;
        step(FL);
        wr(2'd3, 32'h04);
        rd(2'd3);
        chk("race_set_wins", rd0, 32'h04);

        // Masking
        in_port = 7'h04;
        step(ST);
        in_port = 7'h05;
        step(ST);
        wr(2'd2, 32'h02);
        step(1);
        chk("mask_off_irq", {31'd0, irq0}, 32'd0);
        wr(2'd2, 32'h04);
        chk("mask_on_irq_pre", {31'd0, irq0}, 32'd0);
        step(1);
        chk("mask_on_irq", {31'd0, irq0}, 32'd1);
        rd(2'd2);
        chk("mask_read", rd0, 32'h04);

        // Any-edge capture vs rising-only
        wr(2'd3, 32'hFFFFFFFF);
        in_port = 7'h0D;
        step(ST);
        rd(2'd3);
        chk("any_rise_e2", rd2, 32'h08);
        chk("any_rise_e0", rd0, 32'h08);
        wr(2'd3, 32'h08);
        in_port = 7'h05;
        step(ST);
        rd(2'd3);
        chk("any_fall_e2", rd2, 32'h08);
        chk("any_fall_e0", rd0, 32'h0);

        // Asynchronous reset mid-cycle with state pending
        wr(2'd2, 32'h7F);
        in_port = 7'h7F;
        step(ST);
        chk("pre_rst_irq", {31'd0, irq0}, 32'd1);
        in_port = '0;
        step(ST);
        #2 reset = 1'b1;
        #1;
        chk("arst_rd0", rd0, 32'h0);
        chk("arst_irq0", {31'd0, irq0}, 32'd0);
        chk("arst_rd2", rd2, 32'h0);
        chk("arst_irq2", {31'd0, irq2}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a));
            chk($sformatf("post_rst_rd%0d", a), rd0, 32'h0);
        end
        chk("post_rst_irq", {31'd0, irq0}, 32'd0);

`ifdef ALARM_PIO_DEBOUNCE_EN
        wr(2'd2, 32'h01);
        address = 2'd0;
        in_port = 7'h01;
        step(10);
        in_port = '0;
        step(30);
        chk("deb_short_data", rd0, 32'h0);
        rd(2'd3);
        chk("deb_short_cap", rd0, 32'h0);
        address = 2'd0;
        in_port = 7'h01;
        step(18);
        chk("deb_long_data_18", rd0, 32'h0);
        step(1);
        chk("deb_long_data_19", rd0, 32'h1);
        step(1);
        in_port = '0;
        step(ST);
        rd(2'd3);
        chk("deb_long_cap", rd0, 32'h1);
        chk("deb_long_irq", {31'd0, irq0}, 32'd1);
        wr(2'd3, 32'hFFFFFFFF);
        in_port = 7'h01;
        step(10);
        #2 reset = 1'b1;
        in_port = '0;
        @(negedge clk);
        reset = 1'b0;
        step(40);
        rd(2'd3);
        chk("deb_rst_cap", rd0, 32'h0);
        chk("deb_rst_irq", {31'd0, irq0}, 32'd0);
        rd(2'd0);
        chk("deb_rst_data", rd0, 32'h0);
`endif

        // Random traffic against the model
        begin
            int hold;
            hold = 0;
            for (int c = 0; c < 600; c++) begin
                if (hold == 0) begin
                    in_port = W'($urandom);
                    hold = (FL == 2) ? $urandom_range(1, 5) : $urandom_range(1, 30);
                end
                hold--;
                chipselect = 1'($urandom);
                write_n    = 1'($urandom);
                address    = 2'($urandom);
                writedata  = $urandom & $urandom;
                step(1);
            end
            chipselect = 1'b0; write_n = 1'b1;
            step(2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
